cle_label_reader: RTL and testbench

//  Read-back end of the CLE label SRAM. After CLE pulses finish, this block scans the 1024x8 label map.
//  - Repacks the map into the 128x8 binary-image byte format that CLE consumes from ROM (pixel != 0 -> 1).
//  - Builds a table of distinct non-zero labels with per-label pixel area.
//  It sits beside CLE on the shared sram_1024x8_t13 port and is active only after finish.

---
 rtl/cle_pkg.sv | 33 +++
 rtl/cle_label_cam.sv | 96 +++++++++
 rtl/cle_label_reader.sv | 165 ++++++++++++++++
 tb/tb_cle_label_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cle_pkg.sv
// cle_pkg
// Shared constants and types for the CLE label read-back slice.
//   IMG_W / IMG_PIX : image side length and total pixel count of the label map
//   SRAM_AW / ROM_AW: label-SRAM word address width and mask-byte index width
//   MAX_OBJ / AREA_W: label-table depth and per-label area counter width
//   state_t         : read-back sequencer states
//   label_entry_t   : one label-table slot {label, area}
package cle_pkg;

    localparam int IMG_W   = 32;
    localparam int IMG_PIX = IMG_W * IMG_W;
    localparam int SRAM_AW = 10;
    localparam int ROM_AW  = 7;
    localparam int MAX_OBJ = 8;
    localparam int AREA_W  = 11;
    localparam int OBJ_W   = 4;
    localparam int SEL_W   = 3;

    localparam logic [AREA_W-1:0] AREA_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        DONE
    } state_t;

    typedef struct packed {
        logic [7:0]        label;
        logic [AREA_W-1:0] area;
    } label_entry_t;

endpackage

// File: rtl/cle_label_cam.sv
// cle_label_cam
// Small content-addressable table of distinct non-zero labels with a pixel
// area per label. Every entry is compared against the incoming pixel in the
// same cycle, so a hit and an allocation are resolved in one clock.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clear      : empties the table and drops the overflow flag
//   valid      : pixel carries a map word this cycle
//   pixel      : label value read from the map (0 = background)
//   rd_sel     : entry select for the read port
//   obj_cnt    : number of occupied entries
//   overflow   : sticky, a new label was seen while the table was full
//   rd_label   : label of entry rd_sel, 0 when the entry is unused
//   rd_area    : area of entry rd_sel, 0 when the entry is unused
module cle_label_cam
    import cle_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              valid,
    input  logic [7:0]        pixel,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [OBJ_W-1:0]  obj_cnt,
    output logic              overflow,
    output logic [7:0]        rd_label,
    output logic [AREA_W-1:0] rd_area
);

    label_entry_t [MAX_OBJ-1:0] entries_q, entries_d;
    logic [OBJ_W-1:0]           cnt_q, cnt_d;
    logic                       ovf_q, ovf_d;
    logic [MAX_OBJ-1:0]         hit;

    // Only occupied slots may match; an empty slot holds label 0 anyway,
    // but gating by count keeps the intent explicit.
    always_comb begin
        hit = '0;
        for (int i = 0; i < MAX_OBJ; i++) begin
            hit[i] = (OBJ_W'(i) < cnt_q) && (entries_q[i].label == pixel);
        end
    end

    // Hit bumps the matching area (saturating), a miss allocates the next
    // free slot, and a miss on a full table only raises overflow.
    always_comb begin
        entries_d = entries_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        if (clear) begin
            entries_d = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
        end else if (valid && (pixel != 8'd0)) begin
            if (|hit) begin
                for (int i = 0; i < MAX_OBJ; i++) begin
                    if (hit[i] && (entries_q[i].area != AREA_MAX)) begin
                        entries_d[i].area = entries_q[i].area + 1'b1;
                    end
                end
            end else if (cnt_q < OBJ_W'(MAX_OBJ)) begin
                entries_d[cnt_q[SEL_W-1:0]].label = pixel;
                entries_d[cnt_q[SEL_W-1:0]].area  = AREA_W'(1);
                cnt_d = cnt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            entries_q <= entries_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Selects beyond the occupied range read as empty.
    always_comb begin
        rd_label = '0;
        rd_area  = '0;
        if ({1'b0, rd_sel} < cnt_q) begin
            rd_label = entries_q[rd_sel].label;
            rd_area  = entries_q[rd_sel].area;
        end
    end

    assign obj_cnt  = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/cle_label_reader.sv
// cle_label_reader
// Read-back engine for the CLE label SRAM. Once started it walks all map
// words in address order, repacks them into one-bit-per-pixel mask bytes
// (MSB = lowest address) and feeds every word into the label table.
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   start       : scan request, honoured only when idle or finished
//   sram_a      : SRAM read address (0 when not scanning)
//   sram_wen    : SRAM write enable, tied to 1 (read only)
//   sram_q      : SRAM read data, one cycle after the address
//   mask_byte   : most recently completed mask byte
//   mask_idx    : byte index of mask_byte
//   mask_valid  : one-cycle strobe per completed byte
//   busy        : scan in progress
//   done        : scan complete, held until the next accepted start
//   obj_cnt     : distinct labels stored
//   overflow    : sticky table-full indication
//   tbl_sel     : label-table read select
//   tbl_label   : label of selected entry
//   tbl_area    : area of selected entry
module cle_label_reader
    import cle_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [SRAM_AW-1:0] sram_a,
    output logic               sram_wen,
    input  logic [7:0]         sram_q,
    output logic [7:0]         mask_byte,
    output logic [ROM_AW-1:0]  mask_idx,
    output logic               mask_valid,
    output logic               busy,
    output logic               done,
    output logic [OBJ_W-1:0]   obj_cnt,
    output logic               overflow,
    input  logic [SEL_W-1:0]   tbl_sel,
    output logic [7:0]         tbl_label,
    output logic [AREA_W-1:0]  tbl_area
);

    state_t              state_q, state_d;
    logic                accept;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic                q_valid_q, q_valid_d;
    logic [6:0]          shift_q, shift_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [ROM_AW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [ROM_AW-1:0]   mask_idx_q, mask_idx_d;
    logic [7:0]          mask_byte_q, mask_byte_d;
    logic                mask_valid_q, mask_valid_d;
    logic [7:0]          assembled;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // SCAN issues one address per cycle; FLUSH gives the final word its
    // processing cycle before reporting DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    if (addr_q == SRAM_AW'(IMG_PIX - 1)) state_d = FLUSH;
            FLUSH:   state_d = DONE;
            DONE:    if (accept) state_d = SCAN;
            default: state_d = IDLE;
        endcase
    end

    // Status and SRAM-side outputs decoded from the current state.
    always_comb begin
        busy     = (state_q == SCAN) || (state_q == FLUSH);
        done     = (state_q == DONE);
        sram_a   = (state_q == SCAN) ? addr_q : '0;
        sram_wen = 1'b1;
    end

    // Address counter wraps back to 0 after the last word. q_valid marks
    // the cycle in which sram_q holds the word addressed one cycle earlier.
    // The 7-bit shift register plus the incoming pixel bit forms the next
    // mask byte, so the byte is published on the same edge its eighth bit
    // is absorbed.
    always_comb begin
        addr_d       = addr_q;
        q_valid_d    = (state_q == SCAN);
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        mask_idx_d   = mask_idx_q;
        mask_byte_d  = mask_byte_q;
        mask_valid_d = 1'b0;
        assembled    = {shift_q, (sram_q != 8'd0)};

        if (accept) begin
            addr_d      = '0;
            shift_d     = '0;
            bit_cnt_d   = '0;
            byte_cnt_d  = '0;
            mask_idx_d  = '0;
            mask_byte_d = '0;
        end else begin
            if (state_q == SCAN) begin
                addr_d = addr_q + 1'b1;
            end
            if (q_valid_q) begin
                shift_d   = assembled[6:0];
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 3'd7) begin
                    mask_byte_d  = assembled;
                    mask_idx_d   = byte_cnt_q;
                    mask_valid_d = 1'b1;
                    byte_cnt_d   = byte_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q       <= '0;
            q_valid_q    <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            mask_idx_q   <= '0;
            mask_byte_q  <= '0;
            mask_valid_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            q_valid_q    <= q_valid_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            mask_idx_q   <= mask_idx_d;
            mask_byte_q  <= mask_byte_d;
            mask_valid_q <= mask_valid_d;
        end
    end

    assign mask_byte  = mask_byte_q;
    assign mask_idx   = mask_idx_q;
    assign mask_valid = mask_valid_q;

    cle_label_cam u_cam (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .valid    (q_valid_q),
        .pixel    (sram_q),
        .rd_sel   (tbl_sel),
        .obj_cnt  (obj_cnt),
        .overflow (overflow),
        .rd_label (tbl_label),
        .rd_area  (tbl_area)
    );

endmodule

// File: tb/tb_cle_label_reader.sv
// tb_cle_label_reader
// Directed bench for cle_label_reader: a behavioural SRAM holds the label
// map, expected mask bytes are queued per scan and matched against strobes,
// and the label table is compared with a first-appearance reference model.
module tb_cle_label_reader;
    import cle_pkg::*;

    logic              clk;
    logic              reset;
    logic              start;
    logic [9:0]        sram_a;
    logic              sram_wen;
    logic [7:0]        sram_q;
    logic [7:0]        mask_byte;
    logic [6:0]        mask_idx;
    logic              mask_valid;
    logic              busy;
    logic              done;
    logic [3:0]        obj_cnt;
    logic              overflow;
    logic [2:0]        tbl_sel;
    logic [7:0]        tbl_label;
    logic [AREA_W-1:0] tbl_area;

    typedef struct {
        int         idx;
        logic [7:0] byt;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [1024];
    int         checks = 0;
    int         errors = 0;
    int         ncyc = 0;
    int         base = 0;
    int         exp_cnt;
    int         exp_ovf;
    int         exp_lab [8];
    int         exp_area [8];

    cle_label_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sram_a     (sram_a),
        .sram_wen   (sram_wen),
        .sram_q     (sram_q),
        .mask_byte  (mask_byte),
        .mask_idx   (mask_idx),
        .mask_valid (mask_valid),
        .busy       (busy),
        .done       (done),
        .obj_cnt    (obj_cnt),
        .overflow   (overflow),
        .tbl_sel    (tbl_sel),
        .tbl_label  (tbl_label),
        .tbl_area   (tbl_area)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read SRAM: data appears one cycle after the address.
    always @(posedge clk) begin
        sram_q <= mem[sram_a];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter and mask-strobe scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        ncyc = ncyc + 1;
        if (mask_valid === 1'b1) begin
            checkOutput("strobe_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("strobe_idx", mask_idx, e.idx);
                checkOutput("strobe_byte", mask_byte, e.byt);
                checkOutput("strobe_cycle", ncyc - base, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", ncyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearMem();
        for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
    endtask

    task automatic setRange(input int lo, input int n, input logic [7:0] val);
        for (int a = lo; a < lo + n; a++) mem[a] = val;
    endtask

    // Reference table: labels in order of first appearance, table of 8.
    task automatic tableModel();
        int found;
        exp_cnt = 0;
        exp_ovf = 0;
        for (int j = 0; j < 8; j++) begin
            exp_lab[j]  = 0;
            exp_area[j] = 0;
        end
        for (int a = 0; a < 1024; a++) begin
            if (mem[a] != 8'd0) begin
                found = -1;
                for (int j = 0; j < exp_cnt; j++) begin
                    if (exp_lab[j] == int'(mem[a])) found = j;
                end
                if (found >= 0) begin
                    exp_area[found]++;
                end else if (exp_cnt < 8) begin
                    exp_lab[exp_cnt]  = int'(mem[a]);
                    exp_area[exp_cnt] = 1;
                    exp_cnt++;
                end else begin
                    exp_ovf = 1;
                end
            end
        end
    endtask

    task automatic loadExpect();
        exp_t e;
        sb.delete();
        for (int k = 0; k < 128; k++) begin
            e.idx = k;
            e.cyc = 8 * k + 10;
            for (int b = 0; b < 8; b++) e.byt[7-b] = (mem[8*k+b] != 8'd0);
            sb.push_back(e);
        end
        tableModel();
    endtask

    // One-cycle start pulse; base marks the cycle before cycle 1.
    task automatic applyStimulus();
        @(negedge clk);
        #1;
        start = 1'b1;
        base  = ncyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runScan(input int pulse_at);
        int   n;
        logic busy_1025;
        logic [9:0] a_1024;
        loadExpect();
        applyStimulus();
        @(negedge clk);
        #1;
        checkOutput("c1_busy", busy, 1);
        checkOutput("c1_done", done, 0);
        checkOutput("c1_obj_cnt", obj_cnt, 0);
        checkOutput("c1_overflow", overflow, 0);
        checkOutput("c1_sram_a", sram_a, 0);
        n = 1;
        busy_1025 = 1'b0;
        a_1024 = '0;
        while (done !== 1'b1 && n < 1100) begin
            @(negedge clk);
            #1;
            n = ncyc - base;
            start = (pulse_at != 0) && (n == pulse_at);
            if (n == 1024) a_1024 = sram_a;
            if (n == 1025) busy_1025 = busy;
        end
        start = 1'b0;
        checkOutput("done_cycle", n, 1026);
        checkOutput("sram_a_1024", a_1024, 1023);
        checkOutput("busy_1025", busy_1025, 1);
        checkOutput("busy_in_done", busy, 0);
        checkOutput("strobes_left", sb.size(), 0);
        checkOutput("obj_cnt", obj_cnt, exp_cnt);
        checkOutput("overflow", overflow, exp_ovf);
        for (int s = 0; s < 8; s++) begin
            tbl_sel = 3'(s);
            #1;
            checkOutput($sformatf("tbl_label%0d", s), tbl_label, exp_lab[s]);
            checkOutput($sformatf("tbl_area%0d", s), tbl_area, exp_area[s]);
        end
        tbl_sel = '0;
    endtask

    task automatic resetChecks(input string pfx);
        checkOutput({pfx, "_busy"}, busy, 0);
        checkOutput({pfx, "_done"}, done, 0);
        checkOutput({pfx, "_sram_wen"}, sram_wen, 1);
        checkOutput({pfx, "_sram_a"}, sram_a, 0);
        checkOutput({pfx, "_obj_cnt"}, obj_cnt, 0);
        checkOutput({pfx, "_overflow"}, overflow, 0);
        checkOutput({pfx, "_mask_valid"}, mask_valid, 0);
        checkOutput({pfx, "_mask_byte"}, mask_byte, 0);
        checkOutput({pfx, "_mask_idx"}, mask_idx, 0);
        checkOutput({pfx, "_tbl_label"}, tbl_label, 0);
        checkOutput({pfx, "_tbl_area"}, tbl_area, 0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        tbl_sel = '0;
        clearMem();
        repeat (3) @(negedge clk);
        #1;
        resetChecks("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] all-zero map");
        clearMem();
        runScan(0);

        $display("[TB] single label on first byte");
        clearMem();
        setRange(0, 8, 8'h05);
        runScan(0);

        $display("[TB] five labels with distinct areas");
        clearMem();
        setRange(100, 10, 8'h01);
        setRange(200, 20, 8'h02);
        setRange(300, 30, 8'h03);
        setRange(400, 40, 8'h04);
        setRange(500, 50, 8'h05);
        runScan(0);

        $display("[TB] nine labels, table overflow");
        clearMem();
        for (int i = 0; i < 9; i++) mem[i] = 8'(i + 1);
        mem[20] = 8'h01;
        runScan(0);

        $display("[TB] reset in the middle of a scan");
        loadExpect();
        applyStimulus();
        while (ncyc - base < 300) @(negedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        resetChecks("midrst");
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("post_rst_busy", busy, 0);
        runScan(0);

        $display("[TB] start ignored while busy, then rescan from DONE");
        clearMem();
        setRange(100, 10, 8'h01);
        setRange(200, 20, 8'h02);
        setRange(300, 30, 8'h03);
        setRange(400, 40, 8'h04);
        setRange(500, 50, 8'h05);
        runScan(500);
        runScan(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
